// File: rtl/ps2_key_matrix.sv
`timescale 1ns/1ps
// ps2_key_matrix
//   Turns a stream of decoded PS/2 bytes into a COLS x ROWS key-state matrix.
//   The matrix is read back through the system VIA scan interface. An external
//   combinational ROM maps {ext, scancode} to a matrix position, so a different
//   machine layout only needs a different ROM.
//
// Ports
//   clk, nRESET      system clock, synchronous active-low reset
//   clk_en_i         qualifies every state update
//   byte_data_i      received PS/2 byte, taken when byte_valid_i & clk_en_i
//   byte_valid_i     byte_data_i valid
//   map_code_o       {ext, byte_data_i} lookup address to the layout ROM
//   map_valid_i      ROM: map_code_o is a known key
//   map_col_i        ROM: column of the key
//   map_row_i        ROM: row of the key
//   autoscan_i       1: internal column counter selects, 0: column_i selects
//   column_i         addressed column when autoscan_i=0
//   row_i            addressed row
//   column_match_o   any masked row pressed in the selected column
//   row_match_o      matrix bit at [selected column][row_i]
//   row_match_oe_o   enable for the shared row_match line (addressed mode)
//   keys_down_o      number of keys currently held
//   clear_pulse_o    high for one clk after the matrix was cleared
module ps2_key_matrix #(
  parameter int          COLS           = 10,
  parameter int          ROWS           = 8,
  parameter int          CW             = 4,
  parameter int          RW             = 3,
  parameter logic [7:0]  IRQ_ROW_MASK   = 8'hFE,
  parameter int          PREFIX_TIMEOUT = 2048
) (
  input  logic                               clk,
  input  logic                               nRESET,
  input  logic                               clk_en_i,
  input  logic [7:0]                         byte_data_i,
  input  logic                               byte_valid_i,
  output logic [8:0]                         map_code_o,
  input  logic                               map_valid_i,
  input  logic [CW-1:0]                      map_col_i,
  input  logic [RW-1:0]                      map_row_i,
  input  logic                               autoscan_i,
  input  logic [CW-1:0]                      column_i,
  input  logic [RW-1:0]                      row_i,
  output logic                               column_match_o,
  output logic                               row_match_o,
  output logic                               row_match_oe_o,
  output logic [$clog2(COLS*ROWS+1)-1:0]     keys_down_o,
  output logic                               clear_pulse_o
);

  localparam int KW = $clog2(COLS*ROWS+1);
  localparam int TW = $clog2(PREFIX_TIMEOUT+1);

  localparam logic [CW-1:0]      LAST_COL = CW'(COLS-1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(PREFIX_TIMEOUT-1);
  localparam logic [ROWS-1:0]    IRQ_MASK = IRQ_ROW_MASK[ROWS-1:0];
  // One bit per addressable index, set where the index lies inside the
  // matrix; avoids magnitude compares that are constant for full-size sizes.
  localparam logic [2**CW-1:0]   COL_OK   = (2**CW)'({COLS{1'b1}});
  localparam logic [2**RW-1:0]   ROW_OK   = (2**RW)'({ROWS{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                skipLeft_q, skipLeft_d;
  logic [TW-1:0]             timeout_q, timeout_d;
  logic [CW-1:0]             scanCol_q, scanCol_d;
  logic [COLS-1:0][ROWS-1:0] matrix_q, matrix_d;
  logic [KW-1:0]             keysDown_q, keysDown_d;
  logic                      clearPulse_q, clearPulse_d;

  logic                      isSpecial;
  logic                      doMake;
  logic                      doBreak;
  logic                      keyInRange;
  logic                      keyBit;
  logic [CW-1:0]             selCol;
  logic [ROWS-1:0]           selWord;
  logic [2**RW-1:0]          selWordPadded;

  assign map_code_o = {(state_q == S_EXT) || (state_q == S_EXT_BRK), byte_data_i};
  assign isSpecial  = (byte_data_i == 8'h00) || (byte_data_i == 8'hFF) ||
                      (byte_data_i == 8'hAA);
  assign keyInRange = map_valid_i && COL_OK[map_col_i] && ROW_OK[map_row_i];
  assign keyBit     = keyInRange ? matrix_q[map_col_i][map_row_i] : 1'b0;

  // Next-state logic: prefix parser, timeout, matrix write and key count.
  // keys_down only moves when the addressed bit really changes, which makes
  // typematic repeats and breaks of unpressed keys count-neutral.
  always_comb begin
    state_d      = state_q;
    skipLeft_d   = skipLeft_q;
    timeout_d    = timeout_q;
    scanCol_d    = scanCol_q;
    matrix_d     = matrix_q;
    keysDown_d   = keysDown_q;
    clearPulse_d = 1'b0;
    doMake       = 1'b0;
    doBreak      = 1'b0;

    if (clk_en_i) begin
      scanCol_d = (scanCol_q == LAST_COL) ? '0 : scanCol_q + CW'(1);

      if (byte_valid_i) begin
        timeout_d = '0;
        if (isSpecial) begin
          matrix_d     = '0;
          keysDown_d   = '0;
          clearPulse_d = 1'b1;
          state_d      = S_IDLE;
          skipLeft_d   = '0;
        end else begin
          unique case (state_q)
            S_IDLE: begin
              if (byte_data_i == 8'hE0) begin
                state_d = S_EXT;
              end else if (byte_data_i == 8'hF0) begin
                state_d = S_BRK;
              end else if (byte_data_i == 8'hE1) begin
                // Pause sends E1 followed by seven more bytes; swallow them.
                state_d    = S_SKIP;
                skipLeft_d = 3'd7;
              end else begin
                doMake = 1'b1;
              end
            end
            S_EXT: begin
              if (byte_data_i == 8'hF0) begin
                state_d = S_EXT_BRK;
              end else begin
                doMake  = 1'b1;
                state_d = S_IDLE;
              end
            end
            S_BRK, S_EXT_BRK: begin
              doBreak = 1'b1;
              state_d = S_IDLE;
            end
            S_SKIP: begin
              skipLeft_d = skipLeft_q - 3'd1;
              if (skipLeft_q == 3'd1) begin
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end else if (state_q != S_IDLE) begin
        // A stalled prefix is abandoned without touching the matrix.
        if (timeout_q == TMO_LAST) begin
          state_d    = S_IDLE;
          timeout_d  = '0;
          skipLeft_d = '0;
        end else begin
          timeout_d = timeout_q + TW'(1);
        end
      end else begin
        timeout_d = '0;
      end

      if (keyInRange) begin
        if (doMake && !keyBit) begin
          matrix_d[map_col_i][map_row_i] = 1'b1;
          keysDown_d                     = keysDown_q + KW'(1);
        end
        if (doBreak && keyBit) begin
          matrix_d[map_col_i][map_row_i] = 1'b0;
          keysDown_d                     = keysDown_q - KW'(1);
        end
      end
    end
  end

  // All state lives in this single register block with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q      <= S_IDLE;
      skipLeft_q   <= '0;
      timeout_q    <= '0;
      scanCol_q    <= '0;
      matrix_q     <= '0;
      keysDown_q   <= '0;
      clearPulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skipLeft_q   <= skipLeft_d;
      timeout_q    <= timeout_d;
      scanCol_q    <= scanCol_d;
      matrix_q     <= matrix_d;
      keysDown_q   <= keysDown_d;
      clearPulse_q <= clearPulse_d;
    end
  end

  // Scan read-back; a column outside the matrix reads as no keys pressed.
  always_comb begin
    selCol         = autoscan_i ? scanCol_q : column_i;
    selWord        = COL_OK[selCol] ? matrix_q[selCol] : '0;
    selWordPadded  = (2**RW)'(selWord);
    column_match_o = |(selWord & IRQ_MASK);
    row_match_o    = selWordPadded[row_i];
  end

  assign row_match_oe_o = ~autoscan_i;
  assign keys_down_o    = keysDown_q;
  assign clear_pulse_o  = clearPulse_q;

endmodule
